// File: rtl/piir_biquad_mc.sv
// Multi-channel direct-form-I biquad with one time-multiplexed multiplier.
// Per-channel coefficient/history banks, valid/ready sample stream, separate config write port.
module piir_biquad_mc #(
  parameter int W     = 16,
  parameter int N_CH  = 4,
  parameter int GUARD = 4,
  parameter int SAT   = 1,
  localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  Clk1,
  input  logic                  Rst,
  input  logic                  cfg_we,
  input  logic [CHW-1:0]        cfg_ch,
  input  logic [3:0]            cfg_sel,
  input  logic signed [W-1:0]   cfg_data,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CHW-1:0]        in_ch,
  input  logic signed [W-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CHW-1:0]        out_ch,
  output logic signed [W-1:0]   out_data,
  output logic                  busy
);

  localparam int AW = W + GUARD;
  localparam logic [CHW:0] NCH_V = (CHW+1)'(N_CH);
  localparam logic signed [AW-1:0] ACC_MAX = {{(GUARD+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {{(GUARD+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_UPD, S_OUT} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_in_ready;
  logic                  w_busy;
  logic                  w_accept;
  logic                  w_mac;
  logic                  w_upd;
  logic                  w_cfg_rej;

  logic signed [W-1:0]   r_x;
  logic [CHW-1:0]        r_ch;
  logic                  r_bad;
  logic [2:0]            r_tap;
  logic signed [AW-1:0]  r_acc;
  logic signed [W-1:0]   r_out_data;
  logic [CHW-1:0]        r_out_ch;
  logic                  r_out_valid;
  logic                  r_cfg_err;

  logic signed [W-1:0]   r_a1 [N_CH];
  logic signed [W-1:0]   r_a2 [N_CH];
  logic signed [W-1:0]   r_b0 [N_CH];
  logic signed [W-1:0]   r_b1 [N_CH];
  logic signed [W-1:0]   r_b2 [N_CH];
  logic signed [W-1:0]   r_x1 [N_CH];
  logic signed [W-1:0]   r_x2 [N_CH];
  logic signed [W-1:0]   r_y1 [N_CH];
  logic signed [W-1:0]   r_y2 [N_CH];

  logic signed [W-1:0]   w_opa;
  logic signed [W-1:0]   w_opb;
  logic signed [2*W-1:0] w_prod;
  logic signed [AW-1:0]  w_rnd;
  logic signed [W-1:0]   w_y;

  // Keep Q1.(W-1) bits of the product, round half up on the first dropped bit.
  function automatic logic signed [AW-1:0] f_round(input logic signed [2*W-1:0] p);
    logic signed [W-1:0]  t;
    logic signed [AW-1:0] r;
    t = p[2*W-2:W-1];
    r = AW'(t);
    return r + {{(AW-1){1'b0}}, p[W-2]};
  endfunction

  function automatic logic signed [W-1:0] f_sat(input logic signed [AW-1:0] a);
    if (SAT != 0) begin
      if (a > ACC_MAX) return {1'b0, {(W-1){1'b1}}};
      if (a < ACC_MIN) return {1'b1, {(W-1){1'b0}}};
    end
    return a[W-1:0];
  endfunction

  always_ff @(posedge Clk1 or posedge Rst) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_MAC;
      S_MAC:   if (r_tap == 3'd4) w_next = S_UPD;
      S_UPD:   w_next = S_OUT;
      S_OUT:   if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == S_IDLE) && !Rst;
    w_busy     = (r_state != S_IDLE);
    w_accept   = w_in_ready && in_valid;
    w_mac      = (r_state == S_MAC);
    w_upd      = (r_state == S_UPD);
  end

  // A write may not touch the channel whose sample is in flight.
  assign w_cfg_rej = ({1'b0, cfg_ch} >= NCH_V) || (w_busy && (cfg_ch == r_ch));

  always_comb begin
    w_opa = '0;
    w_opb = '0;
    if (!r_bad) begin
      case (r_tap)
        3'd0: begin w_opa = r_b0[r_ch]; w_opb = r_x;        end
        3'd1: begin w_opa = r_b1[r_ch]; w_opb = r_x1[r_ch]; end
        3'd2: begin w_opa = r_b2[r_ch]; w_opb = r_x2[r_ch]; end
        3'd3: begin w_opa = r_a1[r_ch]; w_opb = r_y1[r_ch]; end
        3'd4: begin w_opa = r_a2[r_ch]; w_opb = r_y2[r_ch]; end
        default: ;
      endcase
    end
  end

  assign w_prod = w_opa * w_opb;
  assign w_rnd  = f_round(w_prod);
  assign w_y    = r_bad ? '0 : f_sat(r_acc);

  // Sample capture, MAC accumulation and result register
  always_ff @(posedge Clk1 or posedge Rst) begin
    if (Rst) begin
      r_x         <= '0;
      r_ch        <= '0;
      r_bad       <= 1'b0;
      r_tap       <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && w_cfg_rej;
      if (w_accept) begin
        r_x   <= in_data;
        r_ch  <= in_ch;
        r_bad <= ({1'b0, in_ch} >= NCH_V);
        r_tap <= '0;
        r_acc <= '0;
      end
      if (w_mac) begin
        r_tap <= r_tap + 3'd1;
        r_acc <= (r_tap < 3'd3) ? r_acc + w_rnd : r_acc - w_rnd;
      end
      if (w_upd) begin
        r_out_data  <= w_y;
        r_out_ch    <= r_ch;
        r_out_valid <= 1'b1;
      end
      if ((r_state == S_OUT) && out_ready) r_out_valid <= 1'b0;
    end
  end

  // Coefficient/history banks: history shift on UPD, then config writes
  always_ff @(posedge Clk1 or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_a1[i] <= '0;
        r_a2[i] <= '0;
        r_b0[i] <= '0;
        r_b1[i] <= '0;
        r_b2[i] <= '0;
        r_x1[i] <= '0;
        r_x2[i] <= '0;
        r_y1[i] <= '0;
        r_y2[i] <= '0;
      end
    end else begin
      if (w_upd && !r_bad) begin
        r_x2[r_ch] <= r_x1[r_ch];
        r_x1[r_ch] <= r_x;
        r_y2[r_ch] <= r_y1[r_ch];
        r_y1[r_ch] <= w_y;
      end
      if (cfg_we && !w_cfg_rej) begin
        case (cfg_sel)
          4'd1:  r_a1[cfg_ch] <= cfg_data;
          4'd2:  r_a2[cfg_ch] <= cfg_data;
          4'd5:  r_y1[cfg_ch] <= cfg_data;
          4'd6:  r_y2[cfg_ch] <= cfg_data;
          4'd8:  r_b0[cfg_ch] <= cfg_data;
          4'd9:  r_b1[cfg_ch] <= cfg_data;
          4'd10: r_b2[cfg_ch] <= cfg_data;
          4'd13: r_x1[cfg_ch] <= cfg_data;
          4'd14: r_x2[cfg_ch] <= cfg_data;
          4'd15: begin
            r_x1[cfg_ch] <= '0;
            r_x2[cfg_ch] <= '0;
            r_y1[cfg_ch] <= '0;
            r_y2[cfg_ch] <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = w_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_piir_biquad_mc.sv
// Directed plus randomized bench for piir_biquad_mc against an arithmetic reference model.
module tb_piir_biquad_mc;
  localparam int W = 16, N_CH = 4, GUARD = 4, SAT = 1, CHW = 2;

  logic           Clk1 = 1'b0;
  logic           Rst = 1'b1;
  logic           cfg_we = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [3:0]     cfg_sel = '0;
  logic [W-1:0]   cfg_data = '0;
  logic           cfg_err;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [CHW-1:0] in_ch = '0;
  logic [W-1:0]   in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [CHW-1:0] out_ch;
  logic [W-1:0]   out_data;
  logic           busy;

  int total = 0;
  int bad = 0;
  int bank [N_CH][16];   // indexed by config select code

  piir_biquad_mc #(.W(W), .N_CH(N_CH), .GUARD(GUARD), .SAT(SAT)) dut (
    .Clk1(Clk1), .Rst(Rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data), .busy(busy)
  );

  always #5 Clk1 = ~Clk1;

  task automatic tick();
    @(posedge Clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [15:0] u16(input int v);
    return v[15:0];
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int wrap16(input longint v);
    return int'(((v + 32768) & 65535) - 32768);
  endfunction

  // Product scaled by 2^-15: floor, wrapped to 16 bits, plus the first dropped bit.
  function automatic int rnd(input longint p);
    return wrap16(p >>> 15) + int'((p >>> 14) & 1);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++)
      for (int s = 0; s < 16; s++) bank[c][s] = 0;
  endfunction

  function automatic void model_cfg(input int ch, input int sel, input int v);
    if (sel == 15) begin
      bank[ch][5] = 0; bank[ch][6] = 0; bank[ch][13] = 0; bank[ch][14] = 0;
    end else if (sel inside {1, 2, 5, 6, 8, 9, 10, 13, 14}) begin
      bank[ch][sel] = v;
    end
  endfunction

  function automatic int model_step(input int ch, input int x);
    longint acc;
    int y;
    acc = rnd(longint'(bank[ch][8]) * x) + rnd(longint'(bank[ch][9]) * bank[ch][13])
        + rnd(longint'(bank[ch][10]) * bank[ch][14]) - rnd(longint'(bank[ch][1]) * bank[ch][5])
        - rnd(longint'(bank[ch][2]) * bank[ch][6]);
    if (SAT != 0) y = (acc > 32767) ? 32767 : (acc < -32768) ? -32768 : int'(acc);
    else          y = wrap16(acc);
    bank[ch][14] = bank[ch][13];
    bank[ch][13] = x;
    bank[ch][6]  = bank[ch][5];
    bank[ch][5]  = y;
    return y;
  endfunction

  task automatic do_cfg(input int ch, input int sel, input logic [15:0] d, input bit rej);
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_sel = 4'(sel); cfg_data = d;
    tick();
    cfg_we = 1'b0;
    chk("cfg_err", {31'b0, cfg_err}, {31'b0, rej});
    if (!rej) model_cfg(ch, sel, s16(d));
  endtask

  // Offer one sample (optionally with a config write on the same edge).
  task automatic start(input int ch, input logic [15:0] x, input bit wc,
                       input int cch, input int csel, input logic [15:0] cd, output int y);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_ch = CHW'(ch); in_data = x;
    if (wc) begin
      cfg_we = 1'b1; cfg_ch = CHW'(cch); cfg_sel = 4'(csel); cfg_data = cd;
    end
    tick();
    in_valid = 1'b0; cfg_we = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    if (wc) begin
      chk("cfg_err_same_edge", {31'b0, cfg_err}, 32'd0);
      model_cfg(cch, csel, s16(cd));
    end
    y = model_step(ch, s16(x));
  endtask

  task automatic wait_valid(input int elapsed, output int n);
    n = elapsed;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 20);
  endtask

  task automatic finish_out(input int ch, input int y, input int elapsed);
    int n;
    wait_valid(elapsed, n);
    chk("latency", n, 32'd6);
    chk("out_ch", {30'b0, out_ch}, ch);
    chk("out_data", {16'b0, out_data}, {16'b0, u16(y)});
    tick();
    chk("out_valid_drop", {31'b0, out_valid}, 32'd0);
    chk("in_ready_back", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int y, n, ch, sel;
    int exp2 [5];
    logic [15:0] x, d;
    int sels [5];
    exp2 = '{32'h2000, 0, 32'h1000, 0, 32'h0800};
    sels = '{1, 2, 8, 9, 10};

    // Reset state
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {16'b0, out_data}, 32'd0);
    chk("rst_out_ch", {30'b0, out_ch}, 32'd0);
    chk("rst_cfg_err", {31'b0, cfg_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    Rst = 1'b0;
    model_reset();
    tick();

    // Pass-through
    do_cfg(0, 8, 16'h7FFF, 1'b0);
    start(0, 16'h4000, 1'b0, 0, 0, 16'h0, y);
    repeat (5) tick();
    chk("pass_not_early", {31'b0, out_valid}, 32'd0);
    finish_out(0, 32'h4000, 5);

    // Recursion with interleaved ch1 samples
    do_cfg(0, 15, 16'h0, 1'b0);
    do_cfg(0, 8, 16'h4000, 1'b0);
    do_cfg(0, 1, 16'hC000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) start(0, (i == 0) ? 16'h4000 : 16'h0000, 1'b0, 0, 0, 16'h0, y);
      else            start(1, 16'($urandom_range(0, 65535)), 1'b0, 0, 0, 16'h0, y);
      finish_out((i % 2 == 0) ? 0 : 1, exp2[i], 0);
    end

    // Overflow
    for (int i = 0; i < 5; i++)
      do_cfg(2, (i < 3) ? 8 + i : 13 + (i - 3), 16'h7FFF, 1'b0);
    start(2, 16'h7FFF, 1'b0, 0, 0, 16'h0, y);
    finish_out(2, (SAT != 0) ? 32'h7FFF : 32'h7FFA, 0);

    // Backpressure
    out_ready = 1'b0;
    start(2, 16'h0100, 1'b0, 0, 0, 16'h0, y);
    wait_valid(0, n);
    chk("bp_latency", n, 32'd6);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid_hold", {31'b0, out_valid}, 32'd1);
      chk("bp_data_hold", {16'b0, out_data}, {16'b0, u16(y)});
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);

    // Config collision during MAC
    start(0, 16'h4000, 1'b0, 0, 0, 16'h0, y);
    do_cfg(0, 8, 16'h1234, 1'b1);
    do_cfg(3, 8, 16'h1234, 1'b0);
    chk("cfg_err_pulse_end", {31'b0, cfg_err}, 32'd0);
    finish_out(0, y, 2);
    start(3, 16'h4000, 1'b0, 0, 0, 16'h0, y);
    finish_out(3, 32'h091A, 0);

    // Write and sample on the same IDLE edge
    start(1, 16'h2000, 1'b1, 1, 8, 16'h7FFF, y);
    finish_out(1, 32'h2000, 0);

    // Reset at MAC tap 2
    start(0, 16'h4000, 1'b0, 0, 0, 16'h0, y);
    tick(); tick();
    Rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    Rst = 1'b0;
    model_reset();
    tick();
    start(0, 16'h4000, 1'b0, 0, 0, 16'h0, y);
    finish_out(0, 0, 0);

    // Randomized coefficients and samples
    for (int c = 0; c < N_CH; c++)
      for (int i = 0; i < 5; i++) begin
        d = 16'($urandom_range(0, 65535));
        if (sels[i] <= 2) d = 16'($signed(d) >>> 2);
        do_cfg(c, sels[i], d, 1'b0);
      end
    for (int i = 0; i < 40; i++) begin
      ch = int'($urandom_range(0, N_CH - 1));
      x = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) begin
        sel = int'($urandom_range(0, 15));
        d = 16'($urandom_range(0, 65535));
        start(ch, x, 1'b1, int'($urandom_range(0, N_CH - 1)), sel, d, y);
      end else begin
        start(ch, x, 1'b0, 0, 0, 16'h0, y);
      end
      finish_out(ch, y, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
